// File: rtl/sccb_pkg.sv
// sccb_pkg: state encoding and bus constants shared by the SCCB target files.
package sccb_pkg;
   typedef enum logic [3:0] {
      ST_IDLE, ST_ID, ST_ID_ACK, ST_REG, ST_REG_ACK,
      ST_DATA, ST_DATA_ACK, ST_RD_BYTE, ST_RD_ACK, ST_IGNORE
   } sccb_state_e;
   localparam logic [3:0] BYTE_BITS = 4'd8;
   localparam logic SCCB_ACK = 1'b0;
   localparam logic SCCB_NA  = 1'b1;
   function automatic logic is_ack_slot(input sccb_state_e s);
      return s inside {ST_ID_ACK, ST_REG_ACK, ST_DATA_ACK};
   endfunction
endpackage

// File: rtl/sccb_edge_sync.sv
// sccb_edge_sync: synchronizes SIOC/SIOD and derives SCL edge and START/STOP pulses.
module sccb_edge_sync #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic scl_i,
   input  logic sda_i,
   output logic sda_o,
   output logic scl_rise_o,
   output logic scl_fall_o,
   output logic start_o,
   output logic stop_o
);
   // top bit of each chain is the previous synchronized sample
   logic [STAGES:0] scl_q, sda_q;
   logic scl, scl_p, sda, sda_p;
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         scl_q <= '1;
         sda_q <= '1;
      end else begin
         scl_q <= {scl_q[STAGES-1:0], scl_i};
         sda_q <= {sda_q[STAGES-1:0], sda_i};
      end
   end
   assign scl        = scl_q[STAGES-1];
   assign scl_p      = scl_q[STAGES];
   assign sda        = sda_q[STAGES-1];
   assign sda_p      = sda_q[STAGES];
   assign sda_o      = sda;
   assign scl_rise_o = scl & ~scl_p;
   assign scl_fall_o = ~scl & scl_p;
   assign start_o    = scl & scl_p & sda_p & ~sda;
   assign stop_o     = scl & scl_p & ~sda_p & sda;
endmodule

// File: rtl/sccb_target.sv
// sccb_target: SCCB/I2C target decoding ID/register/data phases into one-cycle write strobes.
// Define SCCB_READ_EN to build the read path (ID SID|1, RD_BYTE/RD_ACK states).
module sccb_target
   import sccb_pkg::*;
#(
   parameter logic [7:0] SID         = 8'h42,
   parameter int         SYNC_STAGES = 2,
   parameter bit         AUTO_INC    = 1'b1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       sioc,
   inout  wire        siod,
   output logic       wr_en,
   output logic [7:0] wr_addr,
   output logic [7:0] wr_data,
   output logic [7:0] rd_addr,
   input  logic [7:0] rd_data,
   output logic       bus_busy
);
   sccb_state_e state_q, state_d;
   logic [7:0] shift_q, shift_d, ptr_q, ptr_d;
   logic [7:0] wr_addr_q, wr_addr_d, wr_data_q, wr_data_d;
   logic [3:0] cnt_q, cnt_d;
   logic wr_en_q, wr_en_d;
   logic sda, scl_rise, scl_fall, start, stop, id_hit, drv_low;

   sccb_edge_sync #(.STAGES(SYNC_STAGES)) u_sync (
      .clk        (clk),
      .rst_n      (rst_n),
      .scl_i      (sioc),
      .sda_i      (siod),
      .sda_o      (sda),
      .scl_rise_o (scl_rise),
      .scl_fall_o (scl_fall),
      .start_o    (start),
      .stop_o     (stop)
   );

`ifdef SCCB_READ_EN
   assign id_hit  = shift_q[7:1] == SID[7:1];
   assign drv_low = is_ack_slot(state_q) || (state_q == ST_RD_BYTE && !shift_q[7]);
`else
   logic unused_rd;
   assign unused_rd = ^rd_data;
   assign id_hit    = shift_q == SID;
   assign drv_low   = is_ack_slot(state_q);
`endif

   always_comb begin
      state_d   = state_q;
      shift_d   = shift_q;
      cnt_d     = cnt_q;
      ptr_d     = (wr_en_q && AUTO_INC) ? ptr_q + 8'd1 : ptr_q;
      wr_en_d   = 1'b0;
      wr_addr_d = wr_addr_q;
      wr_data_d = wr_data_q;
      if (stop) state_d = ST_IDLE;
      else if (start) begin
         state_d = ST_ID;
         cnt_d   = '0;
      end else case (state_q)
         ST_ID, ST_REG, ST_DATA:
            if (scl_rise && cnt_q != BYTE_BITS) begin
               shift_d = {shift_q[6:0], sda};
               cnt_d   = cnt_q + 4'd1;
            end else if (scl_fall && cnt_q == BYTE_BITS) begin
               cnt_d = '0;
               if (state_q == ST_REG) begin
                  state_d = ST_REG_ACK;
                  ptr_d   = shift_q;
               end else if (state_q == ST_DATA) begin
                  state_d   = ST_DATA_ACK;
                  wr_en_d   = 1'b1;
                  wr_addr_d = ptr_q;
                  wr_data_d = shift_q;
               end else state_d = id_hit ? ST_ID_ACK : ST_IGNORE;
            end
`ifdef SCCB_READ_EN
         // shift_q still holds the ID byte here; its LSB selects the read path
         ST_ID_ACK:
            if (scl_fall) begin
               state_d = shift_q[0] ? ST_RD_BYTE : ST_REG;
               shift_d = shift_q[0] ? rd_data : shift_q;
            end
         ST_RD_BYTE:
            if (scl_fall) begin
               shift_d = {shift_q[6:0], 1'b1};
               cnt_d   = (cnt_q == BYTE_BITS - 4'd1) ? 4'd0 : cnt_q + 4'd1;
               state_d = (cnt_q == BYTE_BITS - 4'd1) ? ST_RD_ACK : ST_RD_BYTE;
            end
         // master ACK/NA bit parks in shift_q[0] until the closing fall
         ST_RD_ACK:
            if (scl_rise) begin
               shift_d[0] = sda;
               ptr_d      = AUTO_INC ? ptr_q + 8'd1 : ptr_q;
            end else if (scl_fall) begin
               state_d = (shift_q[0] == SCCB_NA) ? ST_IGNORE : ST_RD_BYTE;
               shift_d = rd_data;
            end
`else
         ST_ID_ACK: if (scl_fall) state_d = ST_REG;
`endif
         ST_REG_ACK, ST_DATA_ACK: if (scl_fall) state_d = ST_DATA;
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         shift_q   <= '0;
         cnt_q     <= '0;
         ptr_q     <= '0;
         wr_en_q   <= 1'b0;
         wr_addr_q <= '0;
         wr_data_q <= '0;
      end else begin
         state_q   <= state_d;
         shift_q   <= shift_d;
         cnt_q     <= cnt_d;
         ptr_q     <= ptr_d;
         wr_en_q   <= wr_en_d;
         wr_addr_q <= wr_addr_d;
         wr_data_q <= wr_data_d;
      end
   end

   assign siod     = drv_low ? 1'b0 : 1'bz;
   assign wr_en    = wr_en_q;
   assign wr_addr  = wr_addr_q;
   assign wr_data  = wr_data_q;
   assign rd_addr  = ptr_q;
   assign bus_busy = state_q != ST_IDLE;
endmodule

// File: tb/tb_sccb_target.sv
// tb_sccb_target: bit-banged SCCB master with a transaction-level model of the register writes.
module tb_sccb_target;
   localparam logic [7:0] SID = 8'h42;
   localparam bit AUTO_INC = 1'b1;

   logic clk, rst_n, scl, m_low, wr_en, bus_busy;
   logic [7:0] wr_addr, wr_data, rd_addr, rd_data;
   wire siod;
   logic [7:0] mem [0:255];
   logic [7:0] tx_data [0:3];
   logic [15:0] exp_q [$];
   logic [15:0] last_wr, e;
   logic [7:0] m_ptr, id, ra, rv;
   logic m_busy, m_drv_ok, a;
   int total, bad, cyc, nwr, w0, m_busy_t, half, nd, ab, abits;

   assign siod = m_low ? 1'b0 : 1'bz;
   pullup (siod);
   assign rd_data = mem[rd_addr];

   sccb_target #(.SID(SID), .SYNC_STAGES(2), .AUTO_INC(AUTO_INC)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .sioc     (scl),
      .siod     (siod),
      .wr_en    (wr_en),
      .wr_addr  (wr_addr),
      .wr_data  (wr_data),
      .rd_addr  (rd_addr),
      .rd_data  (rd_data),
      .bus_busy (bus_busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: time limit reached, cyc=%0d", cyc);
      $fatal(1);
   end

   task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got=%h want=%h (cyc %0d)", nm, act, exp, cyc);
      end
   endtask

   // per-cycle compare against the model
   always begin
      @(posedge clk);
      #1;
      cyc++;
      if (rst_n) begin
         if (wr_en) begin
            nwr++;
            last_wr = {wr_addr, wr_data};
            if (exp_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL wr_unexpected: got=%h want=none", {wr_addr, wr_data});
            end else begin
               e = exp_q.pop_front();
               chk("wr", {wr_addr, wr_data}, e);
            end
         end
         if (!m_low && !m_drv_ok) chk("siod_idle", {15'd0, siod}, 16'd1);
         if (cyc - m_busy_t > 8) chk("bus_busy", {15'd0, bus_busy}, {15'd0, m_busy});
      end
   end

   task automatic hw(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic start();
      m_low = 1'b0;
      hw(half);
      scl = 1'b1;
      hw(half);
      m_low = 1'b1;
      m_busy = 1'b1;
      m_busy_t = cyc;
      hw(half);
      scl = 1'b0;
      hw(2);
   endtask

   task automatic stop();
      m_low = 1'b1;
      hw(half);
      scl = 1'b1;
      hw(half);
      m_low = 1'b0;
      m_busy = 1'b0;
      m_busy_t = cyc;
      hw(half);
   endtask

   task automatic send_bit(input logic b);
      m_low = !b;
      hw(half);
      scl = 1'b1;
      hw(half);
      scl = 1'b0;
      hw(2);
   endtask

   task automatic recv_bit(output logic v);
      m_low = 1'b0;
      hw(half);
      scl = 1'b1;
      hw(half / 2);
      v = siod;
      hw(half - half / 2);
      scl = 1'b0;
      hw(2);
   endtask

   task automatic send_byte(input logic [7:0] b, input logic want);
      logic k;
      for (int i = 7; i >= 0; i--) send_bit(b[i]);
      m_drv_ok = (want == 1'b0);
      recv_bit(k);
      hw(4);
      m_drv_ok = 1'b0;
      chk("ack", {15'd0, k}, {15'd0, want});
   endtask

   // one transaction; ab/abits: abort with STOP after abits bits of byte ab (ab<0: none)
   task automatic xfer(input logic [7:0] xid, input logic [7:0] xra, input int xnd,
                       input int xab, input int xabits);
      logic [7:0] b;
      logic match;
      match = (xid == SID);
      start();
      for (int j = 0; j < 2 + xnd; j++) begin
         b = (j == 0) ? xid : (j == 1) ? xra : tx_data[j-2];
         if (j == xab) begin
            for (int i = 7; i > 7 - xabits; i--) send_bit(b[i]);
            break;
         end
         if (match && j == 1) m_ptr = xra;
         if (match && j >= 2) begin
            exp_q.push_back({m_ptr, b});
            m_ptr = m_ptr + 8'(AUTO_INC);
         end
         send_byte(b, match ? 1'b0 : 1'b1);
      end
      stop();
      hw(10);
      chk("rd_addr", {8'd0, rd_addr}, {8'd0, m_ptr});
      chk("pending", 16'(exp_q.size()), 16'd0);
   endtask

   initial begin
      rst_n = 1'b0; scl = 1'b1; m_low = 1'b0; m_drv_ok = 1'b0; m_busy = 1'b0;
      m_busy_t = 0; m_ptr = 8'd0; half = 11;
      for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
      hw(5);
      chk("rst_wr_en", {15'd0, wr_en}, 16'd0);
      chk("rst_rd_addr", {8'd0, rd_addr}, 16'd0);
      chk("rst_busy", {15'd0, bus_busy}, 16'd0);
      chk("rst_siod", {15'd0, siod}, 16'd1);
      rst_n = 1'b1;
      hw(5);
      // 3-phase write at 200 kHz SIOC (500 clk period)
      half = 250;
      tx_data[0] = 8'h80;
      w0 = nwr;
      xfer(SID, 8'h12, 1, -1, 0);
      chk("t1_nwr", 16'(nwr - w0), 16'd1);
      chk("t1_wr", last_wr, 16'h1280);
      half = 11;
      // foreign ID: no ACKs, no writes
      w0 = nwr;
      tx_data[0] = 8'h33; tx_data[1] = 8'h44;
      xfer(8'h60, 8'h12, 2, -1, 0);
      chk("t2_nwr", 16'(nwr - w0), 16'd0);
      // burst with pointer wrap
      w0 = nwr;
      tx_data[0] = 8'hA5; tx_data[1] = 8'h5A;
      xfer(SID, 8'hFF, 2, -1, 0);
      chk("t3_nwr", 16'(nwr - w0), 16'd2);
      chk("t3_last", last_wr, 16'h005A);
      chk("t3_ptr", {8'd0, rd_addr}, 16'h0001);
      // partial REG byte, then 2-phase write
      w0 = nwr;
      xfer(SID, 8'h77, 0, 1, 5);
      xfer(SID, 8'h0A, 0, -1, 0);
      chk("t4_nwr", 16'(nwr - w0), 16'd0);
      chk("t4_ptr", {8'd0, rd_addr}, 16'h000A);
      // reset after 4 data bits
      w0 = nwr;
      start();
      send_byte(SID, 1'b0);
      send_byte(8'h33, 1'b0);
      for (int i = 7; i > 3; i--) send_bit(1'b1);
      rst_n = 1'b0; m_low = 1'b0; scl = 1'b1; m_busy = 1'b0; m_busy_t = cyc;
      hw(3);
      chk("rr_wr_en", {15'd0, wr_en}, 16'd0);
      chk("rr_wr_addr", {8'd0, wr_addr}, 16'd0);
      chk("rr_wr_data", {8'd0, wr_data}, 16'd0);
      chk("rr_rd_addr", {8'd0, rd_addr}, 16'd0);
      chk("rr_busy", {15'd0, bus_busy}, 16'd0);
      chk("rr_siod", {15'd0, siod}, 16'd1);
      hw(2);
      rst_n = 1'b1;
      m_ptr = 8'd0;
      hw(10);
      tx_data[0] = 8'hC3;
      xfer(SID, 8'h55, 1, -1, 0);
      chk("t5_nwr", 16'(nwr - w0), 16'd1);
      chk("t5_last", last_wr, 16'h55C3);
`ifdef SCCB_READ_EN
      // 2-phase write, repeated START, read one byte, master NA
      mem[8'h1C] = 8'h7F;
      start();
      send_byte(SID, 1'b0);
      send_byte(8'h1C, 1'b0);
      m_ptr = 8'h1C;
      start();
      for (int i = 7; i >= 0; i--) send_bit(SID[i] | (i == 0));
      m_drv_ok = 1'b1;
      recv_bit(a);
      hw(4);
      chk("rd_id_ack", {15'd0, a}, 16'd0);
      rv = 8'd0;
      for (int i = 0; i < 8; i++) begin
         recv_bit(a);
         rv = {rv[6:0], a};
      end
      hw(4);
      m_drv_ok = 1'b0;
      send_bit(1'b1);
      m_ptr = 8'h1D;
      chk("rd_byte", {8'd0, rv}, 16'h007F);
      send_byte(8'h00, 1'b1);
      chk("rd_ignore_busy", {15'd0, bus_busy}, 16'd1);
      stop();
      hw(10);
      chk("rd_ptr", {8'd0, rd_addr}, 16'h001D);
`endif
      // randomized transactions
      for (int t = 0; t < 20; t++) begin
         if ($urandom_range(0, 3) == 0) begin
            do id = 8'($urandom); while (id[7:1] == SID[7:1]);
         end else id = SID;
         ra = 8'($urandom);
         nd = $urandom_range(0, 3);
         for (int k = 0; k < 4; k++) tx_data[k] = 8'($urandom);
         ab = -1;
         abits = 0;
         if ($urandom_range(0, 3) == 0) begin
            ab = $urandom_range(0, 1 + nd);
            abits = $urandom_range(1, 7);
         end
         xfer(id, ra, nd, ab, abits);
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
